// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the pipeline (p0, priority, FP64 lock) and a secondary master (p1).
// Grant is combinational with the request; read-valid returns one cycle after a read grant.
module dmem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,

   input  logic            i_p0_req,
   input  logic            i_p0_lock,
   input  logic [XLEN-1:0] i_p0_addr,
   input  logic [XLEN-1:0] i_p0_wdata,
   input  logic [3:0]      i_p0_be,
   output logic            o_p0_gnt,
   output logic            o_p0_stall,
   output logic            o_p0_rvalid,
   output logic [XLEN-1:0] o_p0_rdata,

   input  logic            i_p1_req,
   input  logic [XLEN-1:0] i_p1_addr,
   input  logic [XLEN-1:0] i_p1_wdata,
   input  logic [3:0]      i_p1_be,
   output logic            o_p1_gnt,
   output logic            o_p1_rvalid,
   output logic [XLEN-1:0] o_p1_rdata,

   output logic            o_mem_en,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   output logic [3:0]      o_mem_be,
   input  logic [XLEN-1:0] i_mem_rdata
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   generate
      if (STARVE_LIMIT < 1) begin : g_bad_limit
         $error("dmem_port_arbiter: STARVE_LIMIT must be >= 1");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_starve_cnt;
   logic [CW-1:0] w_starve_nxt;
   logic          r_p0_rvalid;
   logic          r_p1_rvalid;

   logic          w_cnt_sat;
   logic          w_p0_gnt;
   logic          w_p1_gnt;

   assign w_cnt_sat = (r_starve_cnt == LIMIT_C);

   // Outputs are forced low while reset is asserted, without waiting for a clock edge.
   always_comb begin
      w_p0_gnt = 1'b0;
      w_p1_gnt = 1'b0;
      if (i_rst_n) begin
         if (r_state == ST_LOCKED) begin
            if (i_p0_req)
               w_p0_gnt = 1'b1;
            else if (i_p1_req)
               w_p1_gnt = 1'b1;
         end else begin
            if (i_p1_req && (!i_p0_req || w_cnt_sat))
               w_p1_gnt = 1'b1;
            else if (i_p0_req)
               w_p0_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_p0_gnt && i_p0_lock)
               w_state_nxt = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (w_p0_gnt)
               w_state_nxt = i_p0_lock ? ST_LOCKED : ST_IDLE;
            else if (!i_p0_req)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A locked second beat still counts against p1 but cannot push past the limit.
   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (w_p1_gnt || !i_p1_req)
         w_starve_nxt = '0;
      else if (w_p0_gnt && !w_cnt_sat)
         w_starve_nxt = r_starve_cnt + CW'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_starve_cnt <= '0;
         r_p0_rvalid  <= 1'b0;
         r_p1_rvalid  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_p0_rvalid  <= w_p0_gnt && (i_p0_be == 4'b0000);
         r_p1_rvalid  <= w_p1_gnt && (i_p1_be == 4'b0000);
      end
   end

   always_comb begin
      o_mem_en    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_be    = 4'b0000;
      if (w_p0_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_addr  = i_p0_addr;
         o_mem_wdata = i_p0_wdata;
         o_mem_be    = i_p0_be;
      end else if (w_p1_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_addr  = i_p1_addr;
         o_mem_wdata = i_p1_wdata;
         o_mem_be    = i_p1_be;
      end
   end

   assign o_p0_gnt    = w_p0_gnt;
   assign o_p1_gnt    = w_p1_gnt;
   assign o_p0_stall  = i_rst_n && i_p0_req && !w_p0_gnt;
   assign o_p0_rvalid = r_p0_rvalid;
   assign o_p1_rvalid = r_p1_rvalid;
   assign o_p0_rdata  = {XLEN{i_rst_n}} & i_mem_rdata;
   assign o_p1_rdata  = {XLEN{i_rst_n}} & i_mem_rdata;

   a_gnt_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(o_p0_gnt && o_p1_gnt));

endmodule
